// File: rtl/cpu_pkg.sv
// Shared CPU definitions: bus widths, opcode encodings, prefetch FSM states
// and the layout of one queued instruction.
package cpu_pkg;

    localparam int ADDR_W  = 13;
    localparam int DATA_W  = 8;
    localparam int OP_W    = 3;
    localparam int INSTR_W = 2 * DATA_W;
    localparam int ENTRY_W = INSTR_W + ADDR_W;

    localparam logic [OP_W-1:0] OP_HLT = 3'd0;
    localparam logic [OP_W-1:0] OP_SKZ = 3'd1;
    localparam logic [OP_W-1:0] OP_ADD = 3'd2;
    localparam logic [OP_W-1:0] OP_AND = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR = 3'd4;
    localparam logic [OP_W-1:0] OP_LDA = 3'd5;
    localparam logic [OP_W-1:0] OP_STO = 3'd6;
    localparam logic [OP_W-1:0] OP_JMP = 3'd7;

    typedef enum logic [1:0] {
        S_HI   = 2'd0,
        S_LO   = 2'd1,
        S_FULL = 2'd2,
        S_HALT = 2'd3
    } fetch_state_e;

    // One queue entry: decoded instruction plus the byte address of its high byte.
    typedef struct packed {
        logic [OP_W-1:0]   opcode;
        logic [ADDR_W-1:0] ir_addr;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

    // State to enter once an instruction has been placed in the queue.
    function automatic fetch_state_e after_enqueue(input logic [OP_W-1:0] op);
        return (op == OP_HLT) ? S_HALT : S_HI;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small synchronous FIFO for fetched instructions. Flush empties it and
// overrides any push or pop in the same cycle. A push into a full FIFO is
// accepted when a pop happens in the same cycle.
module instr_fifo #(
    parameter int WIDTH = 29,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             pop_ok;
    logic             push_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem_q[rd_ptr_q];

    // Storage array; no reset so it maps onto plain registers/RAM.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers and occupancy; reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch: reads byte pairs from program ROM, packs them into
// instructions and offers them to the controller through a small queue.
module instr_prefetch
    import cpu_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int ROM_WAIT = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [OP_W-1:0]   opcode,
    output logic [ADDR_W-1:0] ir_addr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              halted
);

    fetch_state_e       state_q,  state_d;
    logic [ADDR_W-1:0]  pc_q,     pc_d;
    logic [2:0]         wait_q,   wait_d;
    logic [DATA_W-1:0]  hi_q,     hi_d;
    logic [ADDR_W-1:0]  hi_pc_q,  hi_pc_d;
    logic [INSTR_W-1:0] hold_q,   hold_d;

    logic               byte_done;
    logic [INSTR_W-1:0] lo_instr;
    logic [INSTR_W-1:0] enq_instr;
    logic               push;
    logic               pop;
    logic               room;
    fetch_entry_t       push_entry;
    fetch_entry_t       head;
    logic [ENTRY_W-1:0] fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;

    assign byte_done = (wait_q == 3'(ROM_WAIT));
    assign lo_instr  = {hi_q, rom_data};
    // In S_FULL the completed instruction comes from the holding register.
    assign enq_instr = (state_q == S_FULL) ? hold_q : lo_instr;
    assign push_entry = fetch_entry_t'({enq_instr, hi_pc_q});

    assign pop  = instr_valid && instr_ready;
    assign room = !fifo_full || pop;

    instr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (push_entry),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Head is presented as zeros while the queue is empty.
    assign head        = fifo_empty ? '0 : fetch_entry_t'(fifo_dout);
    assign instr_valid = !fifo_empty;
    assign opcode      = head.opcode;
    assign ir_addr     = head.ir_addr;
    assign instr_pc    = head.pc;

    // ROM strobe is a state decode; masked during reset so a read aborts at once.
    assign rom_rd   = !reset && ((state_q == S_HI) || (state_q == S_LO));
    assign rom_addr = pc_q;
    assign halted   = (state_q == S_HALT);

    // Fetch state, PC, wait counter and byte latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_HI;
            pc_q    <= '0;
            wait_q  <= '0;
            hi_q    <= '0;
            hi_pc_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wait_q  <= wait_d;
            hi_q    <= hi_d;
            hi_pc_q <= hi_pc_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state logic; a flush overrides whatever the state machine decided.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wait_d  = wait_q;
        hi_d    = hi_q;
        hi_pc_d = hi_pc_q;
        hold_d  = hold_q;
        push    = 1'b0;

        case (state_q)
            S_HI: begin
                if (byte_done) begin
                    hi_d    = rom_data;
                    hi_pc_d = pc_q;
                    pc_d    = pc_q + 1'b1;
                    wait_d  = '0;
                    state_d = S_LO;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_LO: begin
                if (byte_done) begin
                    pc_d   = pc_q + 1'b1;
                    wait_d = '0;
                    hold_d = lo_instr;
                    if (room) begin
                        push    = 1'b1;
                        state_d = after_enqueue(lo_instr[INSTR_W-1 -: OP_W]);
                    end else begin
                        state_d = S_FULL;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_FULL: begin
                if (room) begin
                    push    = 1'b1;
                    state_d = after_enqueue(hold_q[INSTR_W-1 -: OP_W]);
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HI;
            end
        endcase

        if (flush) begin
            state_d = S_HI;
            pc_d    = {flush_pc[ADDR_W-1:1], 1'b0};
            wait_d  = '0;
            push    = 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_prefetch.sv
// Testbench for instr_prefetch: directed scenarios plus randomized flush/ready
// segments, checked against a byte-pair ROM walk model.
module tb_instr_prefetch;
    import cpu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] rom [8192];
    int unsigned cyc = 0;

    // DUT A: zero wait states
    logic        a_reset, a_flush, a_ready, a_rom_rd, a_valid, a_halted;
    logic [12:0] a_flush_pc, a_rom_addr, a_ir, a_pc;
    logic [7:0]  a_rom_data;
    logic [2:0]  a_op;
    // DUT B: three wait states
    logic        b_reset, b_flush, b_ready, b_rom_rd, b_valid, b_halted;
    logic [12:0] b_flush_pc, b_rom_addr, b_ir, b_pc;
    logic [7:0]  b_rom_data;
    logic [2:0]  b_op;

    assign a_rom_data = rom[a_rom_addr];
    assign b_rom_data = rom[b_rom_addr];

    instr_prefetch #(.DEPTH(2), .ROM_WAIT(0)) dut_a (
        .clk(clk), .reset(a_reset), .rom_rd(a_rom_rd), .rom_addr(a_rom_addr),
        .rom_data(a_rom_data), .flush(a_flush), .flush_pc(a_flush_pc),
        .instr_valid(a_valid), .instr_ready(a_ready), .opcode(a_op),
        .ir_addr(a_ir), .instr_pc(a_pc), .halted(a_halted)
    );

    instr_prefetch #(.DEPTH(2), .ROM_WAIT(3)) dut_b (
        .clk(clk), .reset(b_reset), .rom_rd(b_rom_rd), .rom_addr(b_rom_addr),
        .rom_data(b_rom_data), .flush(b_flush), .flush_pc(b_flush_pc),
        .instr_valid(b_valid), .instr_ready(b_ready), .opcode(b_op),
        .ir_addr(b_ir), .instr_pc(b_pc), .halted(b_halted)
    );

    typedef struct packed {
        logic [2:0]  op;
        logic [12:0] ir;
        logic [12:0] pc;
    } rec_t;

    rec_t        got_a[$], got_b[$], exp_q[$];
    int unsigned cyc_a[$], cyc_b[$];
    int          nz_a = 0, nz_b = 0;
    int          vectors = 0, miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every accepted instruction, and any non-zero head shown while empty.
    always @(negedge clk) begin
        if (!a_reset && !a_flush && a_valid && a_ready) begin
            got_a.push_back(rec_t'({a_op, a_ir, a_pc}));
            cyc_a.push_back(cyc);
        end
        if (!b_reset && !b_flush && b_valid && b_ready) begin
            got_b.push_back(rec_t'({b_op, b_ir, b_pc}));
            cyc_b.push_back(cyc);
        end
        if (!a_valid && ({a_op, a_ir, a_pc} != '0)) nz_a <= nz_a + 1;
        if (!b_valid && ({b_op, b_ir, b_pc} != '0)) nz_b <= nz_b + 1;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: walk ROM in byte pairs from an even address until HLT.
    task automatic build_model(input logic [12:0] start, input int max_n);
        logic [12:0] p;
        logic [7:0]  hi, lo;
        exp_q.delete();
        p = {start[12:1], 1'b0};
        for (int i = 0; i < max_n; i++) begin
            hi = rom[p];
            lo = rom[p + 13'd1];
            exp_q.push_back(rec_t'({hi, lo, p}));
            p = p + 13'd2;
            if (hi[7:5] == 3'd0) break;
        end
    endtask

    task automatic cmp_stream(input string tag, input bit use_b, input bit exact);
        int   n;
        rec_t r;
        n = use_b ? got_b.size() : got_a.size();
        if (exact) check({tag, "_count"}, n, exp_q.size());
        else       check({tag, "_bound"}, 32'(n <= exp_q.size()), 1);
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            r = use_b ? got_b[i] : got_a[i];
            check($sformatf("%s_%0d", tag, i), r, exp_q[i]);
        end
    endtask

    task automatic reset_a(input string tag);
        a_reset = 1'b1;
        a_flush = 1'b0;
        tick(2);
        check({tag, "_rst_rd"},    a_rom_rd,   0);
        check({tag, "_rst_addr"},  a_rom_addr, 0);
        check({tag, "_rst_valid"}, a_valid,    0);
        check({tag, "_rst_head"},  {a_op, a_ir, a_pc}, 0);
        check({tag, "_rst_halt"},  a_halted,   0);
        got_a.delete();
        cyc_a.delete();
        a_reset = 1'b0;
    endtask

    initial begin
        int unsigned c0;
        int          rd_cnt;
        logic [12:0] exp_addr;

        a_reset = 1'b1; a_flush = 1'b0; a_ready = 1'b1; a_flush_pc = '0;
        b_reset = 1'b1; b_flush = 1'b0; b_ready = 1'b1; b_flush_pc = '0;
        for (int i = 0; i < 8192; i++) rom[i] = 8'h00;
        rom[0] = 8'hA0; rom[1] = 8'h12; rom[2] = 8'h40; rom[3] = 8'h34;
        rom[4] = 8'hE0; rom[5] = 8'h00; rom[6] = 8'h00; rom[7] = 8'h00;

        // T1: basic stream, latency and spacing
        reset_a("t1");
        c0 = cyc;
        tick(1);
        check("t1_e0_addr", a_rom_addr, 1);
        check("t1_e0_valid", a_valid, 0);
        tick(1);
        check("t1_e1_valid", a_valid, 1);
        check("t1_e1_head", {a_op, a_ir, a_pc}, {OP_LDA, 13'h0012, 13'h0000});
        tick(8);
        check("t1_first_lat", cyc_a.size() > 0 ? cyc_a[0] - c0 : 0, 2);
        check("t1_spacing", cyc_a.size() > 1 ? cyc_a[1] - cyc_a[0] : 0, 2);
        build_model(13'h0000, 16);
        cmp_stream("t1_stream", 1'b0, 1'b1);

        // T3: halt holds, flush restarts at even address
        check("t3_halted", a_halted, 1);
        rd_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (a_rom_rd) rd_cnt++;
        end
        check("t3_rd_while_halt", rd_cnt, 0);
        got_a.delete();
        a_flush = 1'b1; a_flush_pc = 13'h0003;
        tick(1);
        a_flush = 1'b0;
        check("t3_unhalt", a_halted, 0);
        check("t3_addr", a_rom_addr, 13'h0002);
        check("t3_rd", a_rom_rd, 1);
        tick(20);
        build_model(13'h0002, 16);
        cmp_stream("t3_stream", 1'b0, 1'b1);

        // T2: back-pressure fills queue, then drains intact
        a_ready = 1'b0;
        reset_a("t2");
        tick(20);
        check("t2_valid", a_valid, 1);
        check("t2_rd_full", a_rom_rd, 0);
        check("t2_head_pc", a_pc, 13'h0000);
        a_ready = 1'b1;
        tick(20);
        build_model(13'h0000, 16);
        cmp_stream("t2_stream", 1'b0, 1'b1);

        // T4: flush on lo-sample cycle with a pop
        a_ready = 1'b0;
        reset_a("t4");
        tick(3);
        check("t4_pre_valid", a_valid, 1);
        a_ready = 1'b1; a_flush = 1'b1; a_flush_pc = 13'h0004;
        got_a.delete();
        tick(1);
        a_flush = 1'b0;
        check("t4_valid", a_valid, 0);
        check("t4_addr", a_rom_addr, 13'h0004);
        check("t4_rd", a_rom_rd, 1);
        tick(12);
        build_model(13'h0004, 16);
        cmp_stream("t4_stream", 1'b0, 1'b1);

        // T6: three wait states, reset mid-wait
        tick(2);
        b_reset = 1'b0;
        got_b.delete(); cyc_b.delete();
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            exp_addr = (k < 4) ? 13'd0 : (k < 8) ? 13'd1 : 13'd2;
            check($sformatf("t6_addr_%0d", k), b_rom_addr, exp_addr);
            check($sformatf("t6_valid_%0d", k), b_valid, (k >= 8) ? 1 : 0);
        end
        tick(2);
        b_reset = 1'b1;
        #1;
        check("t6_rst_rd_comb", b_rom_rd, 0);
        tick(1);
        check("t6_rst_addr", b_rom_addr, 0);
        check("t6_rst_valid", b_valid, 0);
        check("t6_rst_head", {b_op, b_ir, b_pc}, 0);
        check("t6_rst_halt", b_halted, 0);
        b_reset = 1'b0;
        got_b.delete(); cyc_b.delete();
        c0 = cyc;
        tick(40);
        build_model(13'h0000, 16);
        cmp_stream("t6_stream", 1'b1, 1'b1);
        check("t6_first_lat", cyc_b.size() > 0 ? cyc_b[0] - c0 : 0, 8);
        check("t6_spacing", cyc_b.size() > 1 ? cyc_b[1] - cyc_b[0] : 0, 8);

        // T5: PC wrap across the top of the address space
        rom[13'h1FFE] = 8'hDF; rom[13'h1FFF] = 8'hFF;
        rom[0] = 8'h20; rom[1] = 8'h01;
        a_ready = 1'b1;
        got_a.delete();
        a_flush = 1'b1; a_flush_pc = 13'h1FFE;
        tick(1);
        a_flush = 1'b0;
        tick(30);
        check("t5_first_op", got_a.size() > 0 ? got_a[0].op : 3'd0, OP_STO);
        build_model(13'h1FFE, 16);
        cmp_stream("t5_stream", 1'b0, 1'b1);

        // Randomized segments: random ROM, flush target and ready pattern
        for (int i = 0; i < 8192; i++) rom[i] = 8'($urandom);
        for (int s = 0; s < 30; s++) begin
            got_a.delete();
            a_flush_pc = 13'($urandom);
            a_ready = 1'($urandom);
            a_flush = 1'b1;
            tick(1);
            a_flush = 1'b0;
            for (int c = 0; c < 60; c++) begin
                a_ready = 1'($urandom_range(0, 1));
                tick(1);
            end
            build_model(a_flush_pc, 64);
            check($sformatf("rnd%0d_progress", s), 32'(got_a.size() > 0), 1);
            cmp_stream($sformatf("rnd%0d", s), 1'b0, 1'b0);
        end

        check("empty_head_zero_a", nz_a, 0);
        check("empty_head_zero_b", nz_b, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
